uart_tx_queue: RTL

- Transmit scheduler between the CPU's memory-mapped UART data register and the txuart serializer.
- Buffers CPU byte writes in a FIFO and feeds txuart one byte at a time, obeying its i_wr/o_busy handshake.
- Firmware no longer stalls on every byte. It stalls only when the queue is full.
- Provides a 32-bit status word for the UART control register. Bit 9 keeps its existing meaning of "do not write now", so firmware that polls bit 9 runs unchanged.

---
 rtl/uart_pkg.sv | 19 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_tx_queue.sv | 115 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants: transmit scheduler states, status word
// bit positions and the SOC-wide serializer setup word.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    DRAIN
  } tx_state_e;

  localparam int STAT_OVF_BIT    = 10;
  localparam int STAT_FULL_BIT   = 9;
  localparam int STAT_ACTIVE_BIT = 8;

  // Clocks per bit for 115200 baud from a 100 MHz system clock.
  localparam logic [31:0] UART_SETUP = 32'd868;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and synchronous flush.
// Writes while full and reads while empty are ignored; flush overrides both.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    full    = (count_q == (AW+1)'(DEPTH));
    empty   = (count_q == '0);
    push_ok = push & ~full & ~flush;
    pop_ok  = pop & ~empty & ~flush;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
    rd_data = mem_q[rptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Queues CPU bytes for the txuart serializer and issues them one at a time
// over its i_wr/o_busy handshake; exposes a status word with a sticky overflow.
module uart_tx_queue #(
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int ACK_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_valid,
  input  logic [7:0]  wr_data,
  input  logic        flush,
  input  logic        ovf_clr,
  output logic        tx_wr,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [31:0] status,
  output logic        full,
  output logic        empty
);
  import uart_pkg::*;

  localparam int CW = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;

  tx_state_e     state_q, state_d;
  logic [CW-1:0] ack_cnt_q, ack_cnt_d;
  logic          tx_wr_q, tx_wr_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          ovf_q, ovf_d;
  logic          pop;
  logic [7:0]    fifo_rd;
  logic [AW:0]   count;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush   (flush),
    .push    (wr_valid),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (fifo_rd),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    tx_wr_d   = 1'b0;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && !tx_busy) begin
          state_d   = ISSUE;
          tx_wr_d   = 1'b1;
          tx_data_d = fifo_rd;
        end
      end
      ISSUE: begin
        // A flush during ISSUE leaves the fifo empty, so this pop is ignored there.
        pop       = 1'b1;
        state_d   = WAIT_ACK;
        ack_cnt_d = '0;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_d = DRAIN;
        end else if (ack_cnt_q == CW'(ACK_WAIT - 1)) begin
          state_d = IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Full is the registered value, so a same-edge pop never makes room.
    ovf_d = (wr_valid & full & ~flush) | (ovf_q & ~ovf_clr);

    status                  = '0;
    status[AW:0]            = count;
    status[STAT_ACTIVE_BIT] = (state_q != IDLE) | ~empty;
    status[STAT_FULL_BIT]   = full;
    status[STAT_OVF_BIT]    = ovf_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ack_cnt_q <= '0;
      tx_wr_q   <= 1'b0;
      tx_data_q <= 8'h00;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      tx_wr_q   <= tx_wr_d;
      tx_data_q <= tx_data_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx_wr   = tx_wr_q;
  assign tx_data = tx_data_q;

endmodule
